// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the tile scan-out engine.
//   - default 640x480 @ 800x521 timing constants
//   - rgb332_t colour type {r[2:0], g[2:0], b[1:0]}
//   - code_to_rgb(): default palette contents, used both as the reset image
//     of the writable palette and as the constant ROM when writes are disabled
package vga_pkg;

  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_TOTAL  = 521;
  localparam int DEF_H_PULSE  = 96;
  localparam int DEF_V_PULSE  = 2;
  localparam int DEF_H_BP     = 144;
  localparam int DEF_V_BP     = 31;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  function automatic rgb332_t code_to_rgb(input int unsigned code);
    logic [7:0] v;
    case (code)
      0:       v = 8'h00;
      1:       v = 8'hE0;
      2:       v = 8'hF4;
      3:       v = 8'hF8;
      4:       v = 8'hF8;
      default: v = 8'h92;
    endcase
    return rgb332_t'(v);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: stage-0 raster counters and the raw (unregistered) timing
// flags derived from them.
//   clk, rst        pixel clock, asynchronous active-high reset
//   hc, vc          horizontal / vertical counters (vc steps when hc wraps)
//   active          pixel inside the visible window
//   hsync_raw       low while hc < H_PULSE
//   vsync_raw       low while vc < V_PULSE
//   start           high at hc == 0 && vc == 0
module vga_timing #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 521,
  parameter int H_PULSE  = 96,
  parameter int V_PULSE  = 2,
  parameter int H_BP     = 144,
  parameter int V_BP     = 31,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [$clog2(H_TOTAL)-1:0] hc,
  output logic [$clog2(V_TOTAL)-1:0] vc,
  output logic                       active,
  output logic                       hsync_raw,
  output logic                       vsync_raw,
  output logic                       start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [31:0] hc_w;
  logic [31:0] vc_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == HW'(H_TOTAL - 1)) begin
      hc <= '0;
      if (vc == VW'(V_TOTAL - 1)) vc <= '0;
      else                        vc <= vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Compare at 32 bits so window edges at 0 or at the counter limit do not
  // produce always-true/always-false narrow comparisons.
  assign hc_w = 32'(hc);
  assign vc_w = 32'(vc);

  assign active    = (hc_w >= 32'(H_BP)) && (hc_w < 32'(H_BP + H_ACTIVE)) &&
                     (vc_w >= 32'(V_BP)) && (vc_w < 32'(V_BP + V_ACTIVE));
  assign hsync_raw = !(hc_w < 32'(H_PULSE));
  assign vsync_raw = !(vc_w < 32'(V_PULSE));
  assign start     = (hc == '0) && (vc == '0);

endmodule

// File: rtl/vga_tile_scanout.sv
// vga_tile_scanout: VGA scan-out that fetches one tile code per pixel from an
// external 1-cycle synchronous tile memory and maps it to RGB332 through a
// palette. All video outputs are registered and lag the counters by 2 cycles.
//   dclk, clr                    pixel clock, asynchronous active-high reset
//   tile_rd, tile_addr           tile memory read request (combinational)
//   tile_code                    tile memory data, one cycle after tile_rd
//   pal_we, pal_addr, pal_data   palette write port
//   hsync, vsync                 active-low syncs
//   red, green, blue             RGB332 pixel, zero during blanking
//   frame_start, frame_cnt       frame pulse and 16-bit frame counter
// Build option: VGA_PALETTE_WR_EN makes the palette a writable register file;
// without it the palette is a constant ROM and pal_* are ignored.
//
// Pipeline:
//   stage 0  counters -> tile_rd/tile_addr
//   stage 1  active/syncs/start delayed while the memory returns tile_code
//   stage 2  palette lookup and all outputs registered
module vga_tile_scanout
  import vga_pkg::*;
#(
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int H_PULSE    = DEF_H_PULSE,
  parameter int V_PULSE    = DEF_V_PULSE,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_BP       = DEF_V_BP,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int TILE_SHIFT = 3,
  parameter int CODE_W     = 3,
  parameter int ADDR_W     = 13
) (
  input  logic              dclk,
  input  logic              clr,
  output logic              tile_rd,
  output logic [ADDR_W-1:0] tile_addr,
  input  logic [CODE_W-1:0] tile_code,
  input  logic              pal_we,
  input  logic [CODE_W-1:0] pal_addr,
  input  logic [7:0]        pal_data,
  output logic              hsync,
  output logic              vsync,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              frame_start,
  output logic [15:0]       frame_cnt
);

  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int COLS  = H_ACTIVE >> TILE_SHIFT;
  localparam int ROWS  = V_ACTIVE >> TILE_SHIFT;
  localparam int PAL_N = 1 << CODE_W;

  if ((H_ACTIVE % (1 << TILE_SHIFT)) != 0 || (V_ACTIVE % (1 << TILE_SHIFT)) != 0) begin : g_bad_tile
    $error("vga_tile_scanout: active area is not a whole number of tiles");
  end
  if (longint'(COLS) * longint'(ROWS) > (64'd1 << ADDR_W)) begin : g_bad_addr
    $error("vga_tile_scanout: tile map does not fit in ADDR_W address bits");
  end

  // ---------------- stage 0 ----------------
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic          start;

  vga_timing #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .H_PULSE  (H_PULSE),
    .V_PULSE  (V_PULSE),
    .H_BP     (H_BP),
    .V_BP     (V_BP),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_timing (
    .clk       (dclk),
    .rst       (clr),
    .hc        (hc),
    .vc        (vc),
    .active    (active),
    .hsync_raw (hs_raw),
    .vsync_raw (vs_raw),
    .start     (start)
  );

  // Offsets into the visible window; only meaningful while active, and the
  // address is forced to 0 otherwise so the memory sees a quiet bus.
  logic [31:0] hrel;
  logic [31:0] vrel;
  assign hrel = 32'(hc) - 32'(H_BP);
  assign vrel = 32'(vc) - 32'(V_BP);

  assign tile_rd   = active;
  assign tile_addr = active ? ADDR_W'((vrel >> TILE_SHIFT) * 32'(COLS) + (hrel >> TILE_SHIFT))
                            : '0;

  // ---------------- palette ----------------
  rgb332_t pal_out;

`ifdef VGA_PALETTE_WR_EN
  rgb332_t pal [PAL_N];

  // Writes land at the clock edge, so a lookup at that same edge still
  // reads the previous entry.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= code_to_rgb(i);
    end else if (pal_we) begin
      pal[pal_addr] <= rgb332_t'(pal_data);
    end
  end

  assign pal_out = pal[tile_code];
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_addr, pal_data};
  assign pal_out    = code_to_rgb(32'(tile_code));
`endif

  // ---------------- stage 1 ----------------
  // Sync delays reset high so no spurious sync pulse appears before the
  // counters' first real state reaches the outputs.
  logic active_d;
  logic hs_d;
  logic vs_d;
  logic start_d;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      active_d <= 1'b0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
      start_d  <= 1'b0;
    end else begin
      active_d <= active;
      hs_d     <= hs_raw;
      vs_d     <= vs_raw;
      start_d  <= start;
    end
  end

  // ---------------- stage 2 ----------------
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hsync       <= hs_d;
      vsync       <= vs_d;
      red         <= active_d ? pal_out.r : 3'd0;
      green       <= active_d ? pal_out.g : 3'd0;
      blue        <= active_d ? pal_out.b : 2'd0;
      frame_start <= start_d;
      if (start_d) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_tile_scanout.sv
// tb_vga_tile_scanout: bench for vga_tile_scanout.
// Two instances share one clock: dut_f at the default 640x480 mode (first 40
// lines only) and dut_s in a tiny mode so whole frames fit in the run.
// Each instance has a 1-cycle synchronous tile memory model. Expected values
// come from a raster-position model: after n clock edges since reset release
// the counters sit at raster position n mod frame, and the outputs show
// position n-2.
module tb_vga_tile_scanout;

  typedef struct packed {
    int ht; int vt; int hp; int vp; int hbp; int vbp; int ha; int va; int ts;
  } tm_t;

  localparam tm_t TF = '{800, 521, 96, 2, 144, 31, 640, 480, 3};
  localparam tm_t TS = '{40, 30, 4, 2, 8, 4, 16, 16, 2};
  localparam int  FS = 40 * 30;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic clr_f = 1'b0;
  logic clr_s = 1'b0;
  always #5 clk = ~clk;

  int n_f;
  int n_s;
  always @(posedge clk or posedge clr_f) if (clr_f) n_f <= 0; else n_f <= n_f + 1;
  always @(posedge clk or posedge clr_s) if (clr_s) n_s <= 0; else n_s <= n_s + 1;

  // ---------------- DUT signals ----------------
  logic        rd_f, hs_f, vs_f, fs_f;
  logic [12:0] addr_f;
  logic [2:0]  code_f = '0;
  logic [2:0]  r_f, g_f;
  logic [1:0]  b_f;
  logic [15:0] fc_f;
  logic        we_f = 1'b0;
  logic [2:0]  pa_f = '0;
  logic [7:0]  pd_f = '0;

  logic        rd_s, hs_s, vs_s, fs_s;
  logic [5:0]  addr_s;
  logic [2:0]  code_s = '0;
  logic [2:0]  r_s, g_s;
  logic [1:0]  b_s;
  logic [15:0] fc_s;
  logic        pal_we_s = 1'b0;
  logic [2:0]  pal_addr_s = '0;
  logic [7:0]  pal_data_s = '0;

  vga_tile_scanout dut_f (
    .dclk(clk), .clr(clr_f), .tile_rd(rd_f), .tile_addr(addr_f), .tile_code(code_f),
    .pal_we(we_f), .pal_addr(pa_f), .pal_data(pd_f),
    .hsync(hs_f), .vsync(vs_f), .red(r_f), .green(g_f), .blue(b_f),
    .frame_start(fs_f), .frame_cnt(fc_f)
  );

  vga_tile_scanout #(
    .H_TOTAL(40), .V_TOTAL(30), .H_PULSE(4), .V_PULSE(2), .H_BP(8), .V_BP(4),
    .H_ACTIVE(16), .V_ACTIVE(16), .TILE_SHIFT(2), .CODE_W(3), .ADDR_W(6)
  ) dut_s (
    .dclk(clk), .clr(clr_s), .tile_rd(rd_s), .tile_addr(addr_s), .tile_code(code_s),
    .pal_we(pal_we_s), .pal_addr(pal_addr_s), .pal_data(pal_data_s),
    .hsync(hs_s), .vsync(vs_s), .red(r_s), .green(g_s), .blue(b_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
  );

  // ---------------- tile memories and palette model ----------------
  logic [2:0] mem_f [0:4799];
  logic [2:0] mem_s [0:15];
  logic [7:0] pal_m [0:7];

  always @(posedge clk) if (rd_f) code_f <= mem_f[addr_f];
  always @(posedge clk) if (rd_s) code_s <= mem_s[addr_s];

  // ---------------- reference model ----------------
  function automatic int pos_hc(int n, tm_t t);
    return (n % (t.ht * t.vt)) % t.ht;
  endfunction

  function automatic int pos_vc(int n, tm_t t);
    return (n % (t.ht * t.vt)) / t.ht;
  endfunction

  function automatic bit in_active(int n, tm_t t);
    int h;
    int v;
    h = pos_hc(n, t);
    v = pos_vc(n, t);
    return (h >= t.hbp) && (h < t.hbp + t.ha) && (v >= t.vbp) && (v < t.vbp + t.va);
  endfunction

  function automatic int tile_of(int n, tm_t t);
    if (!in_active(n, t)) return 0;
    return ((pos_vc(n, t) - t.vbp) >> t.ts) * (t.ha >> t.ts) + ((pos_hc(n, t) - t.hbp) >> t.ts);
  endfunction

  function automatic logic [7:0] def_pal(int c);
    logic [7:0] tbl [0:7];
    tbl = '{8'h00, 8'hE0, 8'hF4, 8'hF8, 8'hF8, 8'h92, 8'h92, 8'h92};
    return tbl[c];
  endfunction

  // ---------------- drivers ----------------
  task automatic reset_small();
    clr_s    = 1'b1;
    pal_we_s = 1'b0;
    for (int i = 0; i < 8; i++) pal_m[i] = def_pal(i);
    @(negedge clk);
    @(negedge clk);
    clr_s = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    clr_f = 1'b1;
    clr_s = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (hs_f !== 1'b1) begin errors++; $display("FAIL reset_hsync_f got %b want 1", hs_f); end
    checks++; if (vs_f !== 1'b1) begin errors++; $display("FAIL reset_vsync_f got %b want 1", vs_f); end
    checks++; if ({r_f, g_f, b_f} !== 8'h00) begin errors++; $display("FAIL reset_rgb_f got %h want 00", {r_f, g_f, b_f}); end
    checks++; if (fc_f !== 16'd0) begin errors++; $display("FAIL reset_fcnt_f got %0d want 0", fc_f); end
    checks++; if (fs_f !== 1'b0) begin errors++; $display("FAIL reset_fstart_f got %b want 0", fs_f); end
    checks++; if (rd_f !== 1'b0 || addr_f !== 13'd0) begin errors++; $display("FAIL reset_rd_f got %b/%0d want 0/0", rd_f, addr_f); end
    checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1) begin errors++; $display("FAIL reset_sync_s got %b%b want 11", hs_s, vs_s); end
    checks++; if ({r_s, g_s, b_s} !== 8'h00) begin errors++; $display("FAIL reset_rgb_s got %h want 00", {r_s, g_s, b_s}); end
    checks++; if (fc_s !== 16'd0 || fs_s !== 1'b0) begin errors++; $display("FAIL reset_frame_s got %0d/%b want 0/0", fc_s, fs_s); end
  endtask

  task automatic test_default_mode();
    int n;
    int lows;
    int vlows;
    logic ehs, evs, efs, erd;
    logic [7:0] ergb;
    int eaddr;
    for (int i = 0; i < 4800; i++) mem_f[i] = 3'($urandom_range(0, 7));
    mem_f[0] = 3'd1;
    clr_f = 1'b0;
    lows  = 0;
    vlows = 0;
    repeat (32100) begin
      @(negedge clk);
      n     = n_f;
      erd   = in_active(n, TF);
      eaddr = tile_of(n, TF);
      ehs   = (n < 2) ? 1'b1 : (pos_hc(n - 2, TF) >= TF.hp);
      evs   = (n < 2) ? 1'b1 : (pos_vc(n - 2, TF) >= TF.vp);
      efs   = (n >= 2) && ((n - 2) % (TF.ht * TF.vt) == 0);
      ergb  = (n >= 2 && in_active(n - 2, TF)) ? def_pal(int'(mem_f[tile_of(n - 2, TF)])) : 8'h00;
      checks++; if (hs_f !== ehs) begin errors++; $display("FAIL def_hsync n=%0d got %b want %b", n, hs_f, ehs); end
      checks++; if (vs_f !== evs) begin errors++; $display("FAIL def_vsync n=%0d got %b want %b", n, vs_f, evs); end
      checks++; if (fs_f !== efs) begin errors++; $display("FAIL def_fstart n=%0d got %b want %b", n, fs_f, efs); end
      checks++; if (rd_f !== erd || int'(addr_f) != eaddr) begin errors++; $display("FAIL def_addr n=%0d got %b/%0d want %b/%0d", n, rd_f, addr_f, erd, eaddr); end
      checks++; if ({r_f, g_f, b_f} !== ergb) begin errors++; $display("FAIL def_rgb n=%0d got %h want %h", n, {r_f, g_f, b_f}, ergb); end
      if (pos_hc(n, TF) == 152 && pos_vc(n, TF) == 31) begin
        checks++; if (addr_f !== 13'd1) begin errors++; $display("FAIL addr_152_31 got %0d want 1", addr_f); end
      end
      if (pos_hc(n, TF) == 144 && pos_vc(n, TF) == 39) begin
        checks++; if (addr_f !== 13'd80) begin errors++; $display("FAIL addr_144_39 got %0d want 80", addr_f); end
      end
      if (pos_hc(n, TF) == 143 && pos_vc(n, TF) == 31) begin
        checks++; if (rd_f !== 1'b0 || addr_f !== 13'd0) begin errors++; $display("FAIL addr_143_31 got %b/%0d want 0/0", rd_f, addr_f); end
      end
      if (n == 31 * 800 + 144 + 2) begin
        checks++; if (r_f !== 3'b111 || g_f !== 3'b000 || b_f !== 2'b00) begin errors++; $display("FAIL first_pixel_code1 got %b_%b_%b want 111_000_00", r_f, g_f, b_f); end
      end
      if (n >= 2 && hs_f === 1'b0) lows++;
      if (n >= 2 && vs_f === 1'b0) vlows++;
      if (n >= 2 && (n - 2) % 800 == 799) begin
        checks++; if (lows != 96) begin errors++; $display("FAIL hsync_low_width n=%0d got %0d want 96", n, lows); end
        lows = 0;
      end
    end
    checks++; if (vlows != 1600) begin errors++; $display("FAIL vsync_low_width got %0d want 1600", vlows); end
    clr_f = 1'b1;
  endtask

  task automatic test_frames();
    int n;
    int prev;
    int pulses;
    int vlows;
    logic [15:0] efc;
    for (int i = 0; i < 16; i++) mem_s[i] = 3'($urandom_range(0, 7));
    reset_small();
    prev   = -1;
    pulses = 0;
    vlows  = 0;
    repeat (3 * FS + 10) begin
      @(negedge clk);
      n   = n_s;
      efc = (n < 2) ? 16'd0 : 16'((n - 2) / FS + 1);
      checks++; if (fc_s !== efc) begin errors++; $display("FAIL frame_cnt n=%0d got %0d want %0d", n, fc_s, efc); end
      checks++; if (vs_s !== ((n < 2) ? 1'b1 : (pos_vc(n - 2, TS) >= TS.vp))) begin errors++; $display("FAIL small_vsync n=%0d got %b", n, vs_s); end
      if (fs_s === 1'b1) begin
        pulses++;
        checks++; if (fc_s !== 16'(pulses)) begin errors++; $display("FAIL fcnt_at_pulse got %0d want %0d", fc_s, pulses); end
        if (prev >= 0) begin
          checks++; if (n - prev != FS) begin errors++; $display("FAIL frame_period got %0d want %0d", n - prev, FS); end
        end
        prev = n;
      end
      if (n >= 2 && vs_s === 1'b0) vlows++;
      if (n >= 2 && (n - 2) % FS == FS - 1) begin
        checks++; if (vlows != 2 * TS.ht) begin errors++; $display("FAIL vsync_lines got %0d want %0d", vlows, 2 * TS.ht); end
        vlows = 0;
      end
      if (pos_hc(n, TS) == 23 && pos_vc(n, TS) == 19) begin
        checks++; if (addr_s !== 6'd15) begin errors++; $display("FAIL last_tile_addr got %0d want 15", addr_s); end
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL frame_pulses got %0d want 4", pulses); end
  endtask

  task automatic test_palette();
    int n;
    logic [7:0] ergb;
`ifdef VGA_PALETTE_WR_EN
    for (int i = 0; i < 16; i++) mem_s[i] = 3'd5;
    reset_small();
`else
    for (int i = 0; i < 16; i++) mem_s[i] = 3'd1;
    reset_small();
    pal_we_s   = 1'b1;
    pal_addr_s = 3'd1;
    pal_data_s = 8'h00;
`endif
    repeat (2 * FS + 10) begin
      @(negedge clk);
      n    = n_s;
      ergb = (n >= 2 && in_active(n - 2, TS)) ? pal_m[mem_s[tile_of(n - 2, TS)]] : 8'h00;
      checks++; if ({r_s, g_s, b_s} !== ergb) begin errors++; $display("FAIL pal_rgb n=%0d got %h want %h", n, {r_s, g_s, b_s}, ergb); end
`ifdef VGA_PALETTE_WR_EN
      if (n == 170) begin
        checks++; if ({r_s, g_s, b_s} !== 8'h92) begin errors++; $display("FAIL pal_same_cycle_old got %h want 92", {r_s, g_s, b_s}); end
      end
      if (n == 171) begin
        checks++; if (r_s !== 3'b000 || g_s !== 3'b111 || b_s !== 2'b00) begin errors++; $display("FAIL pal_written_value got %h want 1c", {r_s, g_s, b_s}); end
      end
      if (pal_we_s) pal_m[pal_addr_s] = pal_data_s;
      pal_we_s   = (n == 169);
      pal_addr_s = 3'd5;
      pal_data_s = 8'h1C;
`else
      if (n == 170) begin
        checks++; if ({r_s, g_s, b_s} !== 8'hE0) begin errors++; $display("FAIL pal_rom_ignores_write got %h want e0", {r_s, g_s, b_s}); end
      end
`endif
    end
    pal_we_s = 1'b0;
  endtask

  task automatic test_back_to_back_random();
    int n;
    int eaddr;
    logic [7:0] ergb;
    for (int i = 0; i < 16; i++) mem_s[i] = 3'($urandom_range(0, 7));
    reset_small();
    repeat (3 * FS + 10) begin
      @(negedge clk);
      n     = n_s;
      eaddr = tile_of(n, TS);
      ergb  = (n >= 2 && in_active(n - 2, TS)) ? pal_m[mem_s[tile_of(n - 2, TS)]] : 8'h00;
      checks++; if ({r_s, g_s, b_s} !== ergb) begin errors++; $display("FAIL rand_rgb n=%0d got %h want %h", n, {r_s, g_s, b_s}, ergb); end
      checks++; if (rd_s !== in_active(n, TS) || int'(addr_s) != eaddr) begin errors++; $display("FAIL rand_addr n=%0d got %b/%0d want %b/%0d", n, rd_s, addr_s, in_active(n, TS), eaddr); end
      checks++; if (hs_s !== ((n < 2) ? 1'b1 : (pos_hc(n - 2, TS) >= TS.hp))) begin errors++; $display("FAIL rand_hsync n=%0d got %b", n, hs_s); end
`ifdef VGA_PALETTE_WR_EN
      if (pal_we_s) pal_m[pal_addr_s] = pal_data_s;
`endif
      pal_we_s   = ($urandom_range(0, 19) == 0);
      pal_addr_s = 3'($urandom_range(0, 7));
      pal_data_s = 8'($urandom_range(0, 255));
    end
    pal_we_s = 1'b0;
  endtask

  task automatic test_midframe_clr();
    int n;
    logic [7:0] ergb;
    for (int i = 0; i < 16; i++) mem_s[i] = 3'($urandom_range(0, 7));
    reset_small();
    n = 0;
    while (n < 10 * 40 + 20) begin
      @(negedge clk);
      n = n_s;
    end
    clr_s = 1'b1;
    for (int i = 0; i < 8; i++) pal_m[i] = def_pal(i);
    #1;
    checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1) begin errors++; $display("FAIL clr_sync got %b%b want 11", hs_s, vs_s); end
    checks++; if ({r_s, g_s, b_s} !== 8'h00) begin errors++; $display("FAIL clr_rgb got %h want 00", {r_s, g_s, b_s}); end
    checks++; if (fc_s !== 16'd0 || fs_s !== 1'b0) begin errors++; $display("FAIL clr_frame got %0d/%b want 0/0", fc_s, fs_s); end
    checks++; if (rd_s !== 1'b0 || addr_s !== 6'd0) begin errors++; $display("FAIL clr_counters got %b/%0d want 0/0", rd_s, addr_s); end
    repeat (3) @(negedge clk);
    clr_s = 1'b0;
    repeat (FS + 5) begin
      @(negedge clk);
      n    = n_s;
      ergb = (n >= 2 && in_active(n - 2, TS)) ? pal_m[mem_s[tile_of(n - 2, TS)]] : 8'h00;
      checks++; if (hs_s !== ((n < 2) ? 1'b1 : (pos_hc(n - 2, TS) >= TS.hp))) begin errors++; $display("FAIL restart_hsync n=%0d got %b", n, hs_s); end
      checks++; if ({r_s, g_s, b_s} !== ergb) begin errors++; $display("FAIL restart_rgb n=%0d got %h want %h", n, {r_s, g_s, b_s}, ergb); end
      if (n == 2) begin
        checks++; if (hs_s !== 1'b0 || fs_s !== 1'b1 || fc_s !== 16'd1) begin errors++; $display("FAIL restart_first_line got hs=%b fs=%b fc=%0d want 0/1/1", hs_s, fs_s, fc_s); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_mode();
    test_frames();
    test_palette();
    test_back_to_back_random();
    test_midframe_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
